// File: rtl/snd_arb_pkg.sv
// ----------------------------------------------------------------------------
// snd_arb_pkg
// Shared definitions for the sound event arbiter: FSM state encoding, named
// source indices, the drop counter ceiling and a saturating increment helper.
// No ports (package).
// ----------------------------------------------------------------------------
package snd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Source indices; index 0 has the lowest fixed priority.
    localparam int SRC_SHOT  = 0;
    localparam int SRC_MOVE  = 1;
    localparam int SRC_KILL  = 2;
    localparam int SRC_START = 3;

    localparam logic [7:0] DROP_MAX = 8'd255;

    // Increment that sticks at DROP_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == DROP_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sound_event_arbiter_if.sv
// ----------------------------------------------------------------------------
// sound_event_arbiter_if
// Bundles the event-side request pulses and the tone-generator-side outputs of
// the sound event arbiter.
//   ev_req    event pulses, one bit per source (driven by the event logic)
//   snd_sel   one-hot sound select, all-zero = silence
//   busy      arbiter is playing or in the silent gap
//   grant_id  index of the source currently/last granted
//   snd_done  one-cycle pulse on the final play cycle
//   drop_cnt  saturating count of coalesced requests
// Modports: master = event logic side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface sound_event_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
    logic [N_SRC-1:0] ev_req;
    logic [N_SRC-1:0] snd_sel;
    logic             busy;
    logic [ID_W-1:0]  grant_id;
    logic             snd_done;
    logic [7:0]       drop_cnt;

    modport master (
        output ev_req,
        input  snd_sel,
        input  busy,
        input  grant_id,
        input  snd_done,
        input  drop_cnt
    );

    modport slave (
        input  ev_req,
        output snd_sel,
        output busy,
        output grant_id,
        output snd_done,
        output drop_cnt
    );
endinterface

// File: rtl/snd_arb_picker.sv
// ----------------------------------------------------------------------------
// snd_arb_picker
// Combinational winner select over the pending request vector.
//   pending    in   N_SRC  sticky pending requests
//   rr_ptr     in   ID_W   round-robin start index (only with
//                          SND_ARB_ROUND_ROBIN_EN defined)
//   win_id     out  ID_W   index of the selected source
//   win_valid  out  1      at least one request is pending
// Configuration macro SND_ARB_ROUND_ROBIN_EN:
//   defined   -> search starts at rr_ptr and walks upward with wrap
//   undefined -> fixed priority, highest index wins
// ----------------------------------------------------------------------------
module snd_arb_picker #(
    parameter int N_SRC = 4,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] pending,
`ifdef SND_ARB_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  rr_ptr,
`endif
    output logic [ID_W-1:0]  win_id,
    output logic             win_valid
);

    assign win_valid = |pending;

`ifdef SND_ARB_ROUND_ROBIN_EN
    // Candidate k is (rr_ptr + k) mod N_SRC. Both operands are below N_SRC,
    // so a single conditional subtract performs the wrap.
    logic [ID_W:0]   rot_sum  [N_SRC];
    logic [ID_W-1:0] cand_idx [N_SRC];
    logic            found;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cand
        assign rot_sum[gi]  = {1'b0, rr_ptr} + (ID_W+1)'(gi);
        assign cand_idx[gi] = (rot_sum[gi] >= (ID_W+1)'(N_SRC))
                            ? ID_W'(rot_sum[gi] - (ID_W+1)'(N_SRC))
                            : ID_W'(rot_sum[gi]);
    end

    always_comb begin
        win_id = '0;
        found  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && pending[cand_idx[k]]) begin
                win_id = cand_idx[k];
                found  = 1'b1;
            end
        end
    end
`else
    // Ascending scan: the last pending bit seen (the highest index) wins.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pending[i]) begin
                win_id = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/sound_event_arbiter.sv
// ----------------------------------------------------------------------------
// sound_event_arbiter
// Shares the single I2S tone generator among game event sources. One-cycle
// event pulses are latched as sticky pending requests; one source at a time
// is granted and its one-hot select is held for PLAY_CYCLES cycles, followed
// by GAP_CYCLES cycles of silence. There is no preemption.
// Ports:
//   clk       in   1      system clock
//   reset_n   in   1      asynchronous active-low reset
//   bus       slave modport of sound_event_arbiter_if
//             (ev_req in; snd_sel, busy, grant_id, snd_done, drop_cnt out)
// Configuration macro SND_ARB_ROUND_ROBIN_EN: round-robin arbitration when
// defined (pointer advances past each winner), fixed highest-index priority
// when undefined.
// ----------------------------------------------------------------------------
module sound_event_arbiter
    import snd_arb_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int PLAY_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int CNT_W       = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sound_event_arbiter_if.slave  bus
);

    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  timer_reg, timer_next;
    logic [N_SRC-1:0]  pending_reg, pending_next;
    logic [N_SRC-1:0]  snd_sel_reg, snd_sel_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic [7:0]        drop_cnt_reg, drop_cnt_next;

    logic [ID_W-1:0]   win_id;
    logic              win_valid;
    logic [N_SRC-1:0]  win_onehot;
    logic [N_SRC-1:0]  clear_mask;
    logic              grant;

`ifdef SND_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
`endif

    snd_arb_picker #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_picker (
        .pending   (pending_reg),
`ifdef SND_ARB_ROUND_ROBIN_EN
        .rr_ptr    (rr_ptr_reg),
`endif
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_id == ID_W'(gi));
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        snd_sel_next  = snd_sel_reg;
        grant_id_next = grant_id_reg;
        drop_cnt_next = drop_cnt_reg;
        clear_mask    = '0;
        grant         = 1'b0;
`ifdef SND_ARB_ROUND_ROBIN_EN
        rr_ptr_next   = rr_ptr_reg;
`endif

        unique case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    grant = 1'b1;
                end
            end
            ST_PLAY: begin
                if (timer_reg == '0) begin
                    state_next   = ST_GAP;
                    timer_next   = GAP_LOAD;
                    snd_sel_next = '0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            ST_GAP: begin
                // On the last gap cycle a waiting request is granted straight
                // away so no idle cycle is inserted between sounds.
                if (timer_reg == '0) begin
                    if (win_valid) begin
                        grant = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                snd_sel_next = '0;
            end
        endcase

        if (grant) begin
            state_next    = ST_PLAY;
            timer_next    = PLAY_LOAD;
            snd_sel_next  = win_onehot;
            grant_id_next = win_id;
            clear_mask    = win_onehot;
`ifdef SND_ARB_ROUND_ROBIN_EN
            rr_ptr_next   = (win_id == ID_W'(N_SRC - 1)) ? '0 : win_id + 1'b1;
`endif
        end

        // A pulse arriving while its bit is being cleared by this grant is a
        // fresh request: it re-sets the bit and is not counted as a drop.
        pending_next = (pending_reg & ~clear_mask) | bus.ev_req;
        if (|(bus.ev_req & pending_reg & ~clear_mask)) begin
            drop_cnt_next = sat_inc(drop_cnt_reg);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= '0;
            pending_reg  <= '0;
            snd_sel_reg  <= '0;
            grant_id_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            pending_reg  <= pending_next;
            snd_sel_reg  <= snd_sel_next;
            grant_id_reg <= grant_id_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

`ifdef SND_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`endif

    // snd_sel comes straight from a register so the tone generator never sees
    // decode glitches; the async reset silences it immediately.
    assign bus.snd_sel  = snd_sel_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.grant_id = grant_id_reg;
    assign bus.snd_done = (state_reg == ST_PLAY) && (timer_reg == '0);
    assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_sound_event_arbiter.sv
module tb_sound_event_arbiter;
    import snd_arb_pkg::*;

    localparam int PLAY = 8;
    localparam int GAP  = 3;
    localparam int N    = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sound_event_arbiter_if #(.N_SRC(N), .ID_W(2)) bus();

    sound_event_arbiter #(
        .N_SRC       (N),
        .PLAY_CYCLES (PLAY),
        .GAP_CYCLES  (GAP),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- behavioural model ----------------
    // A sound is described only by the cycle it starts and its source: it is
    // audible for PLAY cycles, the arbiter is busy for PLAY+GAP cycles, and a
    // new winner may be chosen on the last busy cycle or any later cycle.
    longint     cyc     = 0;
    longint     m_start = -1000;
    logic [1:0] m_src   = '0;
    logic [3:0] m_pend  = '0;
    logic [7:0] m_drop  = '0;
    logic [1:0] m_rr    = '0;

    logic       m_grant;
    logic [1:0] m_w;
    logic [3:0] m_clr;
    logic       m_dropev;

    function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] rr);
        logic [1:0] r;
        r = 2'd0;
`ifdef SND_ARB_ROUND_ROBIN_EN
        for (int k = 3; k >= 0; k--) begin
            if (p[(int'(rr) + k) % N]) r = 2'((int'(rr) + k) % N);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (p[i]) r = 2'(i);
        end
`endif
        return r;
    endfunction

    always_comb begin
        m_clr    = '0;
        m_w      = '0;
        m_grant  = (cyc >= m_start + PLAY + GAP - 1) && (m_pend != 4'd0);
        if (m_grant) begin
            m_w        = pick(m_pend, m_rr);
            m_clr[m_w] = 1'b1;
        end
        m_dropev = ((bus.ev_req & m_pend & ~m_clr) != 4'd0);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_start <= -1000;
            m_src   <= '0;
            m_pend  <= '0;
            m_drop  <= '0;
            m_rr    <= '0;
        end else begin
            m_pend <= (m_pend & ~m_clr) | bus.ev_req;
            if (m_dropev && m_drop != DROP_MAX) m_drop <= m_drop + 8'd1;
            if (m_grant) begin
                m_start <= cyc + 1;
                m_src   <= m_w;
                m_rr    <= m_w + 2'd1;
            end
        end
    end

    logic [3:0] exp_sel;
    logic       exp_busy;
    logic       exp_done;
    logic [1:0] exp_gid;
    logic [7:0] exp_drop;

    always_comb begin
        exp_sel  = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_gid  = '0;
        exp_drop = '0;
        if (reset_n) begin
            if (cyc >= m_start && cyc < m_start + PLAY) exp_sel[m_src] = 1'b1;
            exp_busy = (cyc >= m_start) && (cyc < m_start + PLAY + GAP);
            exp_done = (cyc == m_start + PLAY - 1);
            exp_gid  = m_src;
            exp_drop = m_drop;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, expv);
    endtask

    // Compare process: every cycle, at the falling edge.
    always @(negedge clk) begin
        check("snd_sel",  64'(bus.snd_sel),  64'(exp_sel));
        check("busy",     64'(bus.busy),     64'(exp_busy));
        check("snd_done", 64'(bus.snd_done), 64'(exp_done));
        check("grant_id", 64'(bus.grant_id), 64'(exp_gid));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
        check("onehot0",  64'($onehot0(bus.snd_sel)), 64'd1);
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input longint target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m);
        bus.ev_req = m;
        @(posedge clk);
        #1;
        bus.ev_req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        longint t0;
        bus.ev_req = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_sel",  64'(bus.snd_sel),  64'd0);
        check("rst_busy", 64'(bus.busy),     64'd0);
        check("rst_gid",  64'(bus.grant_id), 64'd0);
        check("rst_drop", 64'(bus.drop_cnt), 64'd0);
        check("rst_done", 64'(bus.snd_done), 64'd0);
        #1 reset_n = 1'b1;

        // 1: single shot request
        t0 = cyc;
        pulse(4'b0001);
        wait_cyc(t0 + 1);  check("t1_sel_t1",  64'(bus.snd_sel), 64'h0);
        wait_cyc(t0 + 2);  check("t1_sel_t2",  64'(bus.snd_sel), 64'h1);
                           check("t1_gid",     64'(bus.grant_id), 64'd0);
        wait_cyc(t0 + 8);  check("t1_done_t8", 64'(bus.snd_done), 64'd0);
        wait_cyc(t0 + 9);  check("t1_sel_t9",  64'(bus.snd_sel), 64'h1);
                           check("t1_done_t9", 64'(bus.snd_done), 64'd1);
        wait_cyc(t0 + 10); check("t1_sel_t10", 64'(bus.snd_sel), 64'h0);
                           check("t1_busy_gap",64'(bus.busy), 64'd1);
        wait_cyc(t0 + 12); check("t1_busy_t12",64'(bus.busy), 64'd1);
        wait_cyc(t0 + 13); check("t1_busy_t13",64'(bus.busy), 64'd0);

        // 2: simultaneous shot + kill, from a fresh reset (rr pointer 0)
        do_reset();
        t0 = cyc;
        pulse(4'b0101);
`ifdef SND_ARB_ROUND_ROBIN_EN
        wait_cyc(t0 + 2);  check("t2_first",  64'(bus.snd_sel), 64'h1);
                           check("t2_gid1",   64'(bus.grant_id), 64'd0);
        wait_cyc(t0 + 13); check("t2_second", 64'(bus.snd_sel), 64'h4);
                           check("t2_gid2",   64'(bus.grant_id), 64'd2);
`else
        wait_cyc(t0 + 2);  check("t2_first",  64'(bus.snd_sel), 64'h4);
                           check("t2_gid1",   64'(bus.grant_id), 64'd2);
        wait_cyc(t0 + 13); check("t2_second", 64'(bus.snd_sel), 64'h1);
                           check("t2_gid2",   64'(bus.grant_id), 64'd0);
`endif
        wait_cyc(t0 + 24); check("t2_idle",   64'(bus.busy), 64'd0);

        // 3: kill pulsed three times during its own play
        t0 = cyc;
        pulse(4'b0100);
        wait_cyc(t0 + 3); pulse(4'b0100);
        wait_cyc(t0 + 5); pulse(4'b0100);
        wait_cyc(t0 + 7); pulse(4'b0100);
        wait_cyc(t0 + 9);  check("t3_drop",   64'(bus.drop_cnt), 64'd2);
        wait_cyc(t0 + 13); check("t3_replay", 64'(bus.snd_sel), 64'h4);
        wait_cyc(t0 + 24); check("t3_idle",   64'(bus.busy), 64'd0);
                           check("t3_drop_end", 64'(bus.drop_cnt), 64'd2);

        // 5: move re-requested on its exact grant cycle
        t0 = cyc;
        pulse(4'b0010);
        pulse(4'b0010);
        wait_cyc(t0 + 2);  check("t5_first",  64'(bus.snd_sel), 64'h2);
        wait_cyc(t0 + 13); check("t5_second", 64'(bus.snd_sel), 64'h2);
                           check("t5_drop",   64'(bus.drop_cnt), 64'd2);
        wait_cyc(t0 + 24); check("t5_idle",   64'(bus.busy), 64'd0);

        // 4: asynchronous reset in the middle of a play with a request pending
        t0 = cyc;
        pulse(4'b1000);
        wait_cyc(t0 + 4); pulse(4'b0001);
        wait_cyc(t0 + 6); check("t4_playing", 64'(bus.snd_sel), 64'h8);
        #2 reset_n = 1'b0;
        #1;
        check("t4_async_sel",  64'(bus.snd_sel),  64'd0);
        check("t4_async_busy", 64'(bus.busy),     64'd0);
        check("t4_async_drop", 64'(bus.drop_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        t0 = cyc;
        wait_cyc(t0 + 15);
        check("t4_silent_sel",  64'(bus.snd_sel), 64'd0);
        check("t4_silent_busy", 64'(bus.busy),    64'd0);

        // 6: 300 cycles of continuous shot requests -> drop counter saturates
        bus.ev_req = 4'(1 << SRC_SHOT);
        repeat (300) @(posedge clk);
        #1 bus.ev_req = '0;
        @(negedge clk);
        check("t6_sat", 64'(bus.drop_cnt), 64'd255);
        t0 = cyc;
        wait_cyc(t0 + 40);
        check("t6_hold", 64'(bus.drop_cnt), 64'd255);
        check("t6_idle", 64'(bus.busy),     64'd0);
        check("t6_sel",  64'(bus.snd_sel),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
